// File: rtl/mem_port_responder_if.sv
// Request/response bus of the single-beat memory port.
// With MEM_RESP_RANGE_CHECK_EN defined the bus also carries mem_err.
interface mem_port_responder_if;
    logic        mem_request_enable;
    logic        mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_response_enable;
    logic [31:0] mem_data;
`ifdef MEM_RESP_RANGE_CHECK_EN
    logic        mem_err;

    modport master (
        output mem_request_enable, mem_mode, mem_addr, mem_wdata, mem_wstrb,
        input  mem_response_enable, mem_data, mem_err
    );
    modport slave (
        input  mem_request_enable, mem_mode, mem_addr, mem_wdata, mem_wstrb,
        output mem_response_enable, mem_data, mem_err
    );
`else
    modport master (
        output mem_request_enable, mem_mode, mem_addr, mem_wdata, mem_wstrb,
        input  mem_response_enable, mem_data
    );
    modport slave (
        input  mem_request_enable, mem_mode, mem_addr, mem_wdata, mem_wstrb,
        output mem_response_enable, mem_data
    );
`endif
endinterface

// File: rtl/mem_port_responder.sv
// mem_port_responder: responder end of the single-beat memory port.
// Serves requests from a word-addressed RAM after a fixed LATENCY
// (1..15 cycles), with one request held in a skid buffer while busy.
// Optional MEM_RESP_RANGE_CHECK_EN: flag out-of-range offsets with mem_err
// and return 32'hDEAD_BEEF; without it addresses alias modulo RAM size.

// One byte lane of the RAM: async read, write on clock edge.
module mem_port_responder_lane #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0] mem [0:DEPTH-1];

    // Byte write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module mem_port_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_responder_if.slave  bus,
    output logic                 overflow
);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  BUSY     = 1'b1;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic                  mode;
        logic [ADDR_WIDTH-1:0] idx;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
        logic                  err;
    } req_t;

    logic [0:0]  state;
    logic [3:0]  cnt;
    req_t        act;
    req_t        skid;
    logic        skid_vld;
    req_t        inc;
    logic [31:0] off;
    logic        resp;
    logic        commit;
    logic [3:0]  lane_we;
    logic [31:0] rd_word;

    // Decode the incoming request into the internal request format.
    always_comb begin
        off       = bus.mem_addr - BASE_ADDR;
        inc.mode  = bus.mem_mode;
        inc.idx   = off[ADDR_WIDTH+1:2];
        inc.wdata = bus.mem_wdata;
        inc.wstrb = bus.mem_wstrb;
`ifdef MEM_RESP_RANGE_CHECK_EN
        inc.err   = |off[31:ADDR_WIDTH+2];
`else
        inc.err   = 1'b0;
`endif
    end

    // Byte-offset bits (and, without range check, the aliased upper bits)
    // are intentionally ignored.
    logic unused_off;
`ifdef MEM_RESP_RANGE_CHECK_EN
    assign unused_off = ^off[1:0];
`else
    assign unused_off = ^{off[31:ADDR_WIDTH+2], off[1:0]};
`endif

    // The response cycle is the BUSY cycle where the countdown hits zero.
    assign resp    = (state == BUSY) && (cnt == 4'd0);
    assign commit  = resp && act.mode && !act.err;
    assign lane_we = {4{commit}} & act.wstrb;

    mem_port_responder_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane [3:0] (
        .clk   (clk),
        .we    (lane_we),
        .idx   (act.idx),
        .wdata (act.wdata),
        .rdata (rd_word)
    );

    // Control: accept, count down, hand over from skid buffer, detect drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            act      <= '0;
            skid     <= '0;
            skid_vld <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_request_enable) begin
                        act   <= inc;
                        cnt   <= CNT_INIT;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        if (bus.mem_request_enable) begin
                            if (!skid_vld) begin
                                skid     <= inc;
                                skid_vld <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end else if (skid_vld) begin
                        // Skid slot frees this cycle, so a coincident strobe
                        // refills it instead of being dropped.
                        act <= skid;
                        cnt <= CNT_INIT;
                        if (bus.mem_request_enable) skid <= inc;
                        else                        skid_vld <= 1'b0;
                    end else if (bus.mem_request_enable) begin
                        act <= inc;
                        cnt <= CNT_INIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response outputs; data is zero outside the response cycle and on writes.
    always_comb begin
        bus.mem_response_enable = resp;
        bus.mem_data            = 32'h0;
        if (resp) begin
            if (act.err)       bus.mem_data = ERR_DATA;
            else if (!act.mode) bus.mem_data = rd_word;
        end
`ifdef MEM_RESP_RANGE_CHECK_EN
        bus.mem_err = resp && act.err;
`endif
    end
endmodule

// File: doc/mem_port_responder.md
Name: mem_port_responder

Overview:
- Target (responder) end of the single-beat request/response memory port used by the virtio block: `mem_request_enable`/`mem_mode`/`mem_addr`/`mem_wdata`/`mem_wstrb` in, `mem_response_enable`/`mem_data` out.
- Serves requests from an internal word-addressed RAM with a fixed, parameterised latency.
- Holds one request in a skid buffer while busy.
- Used as the descriptor/buffer memory model in block-level benches and as a scratch RAM in the SoC.

Parameters:
- ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words.
- LATENCY, 2, cycles from request acceptance to response pulse; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address mapped to RAM word 0; must be 4-byte aligned.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_request_enable  in  1  one-cycle request strobe.
- mem_mode  in  1  0 = read, 1 = write; sampled with strobe.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte enables for writes; bit n enables byte n.
- mem_response_enable  out  1  one-cycle response strobe.
- mem_data  out  32  read data, valid only while mem_response_enable is high.
- overflow  out  1  sticky: a request was dropped because both slots were full.

Behaviour:
- Interface is fixed: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: mem_response_enable=0, mem_data=0, overflow=0, state IDLE, skid buffer empty, counter 0. RAM contents are not reset.
- Asserting rst mid-operation abandons the active and buffered requests; no response is issued for either.
- Offset and index:
  - off = mem_addr - BASE_ADDR (32-bit, wrapping).
  - idx = off[ADDR_WIDTH+1:2].
  - Without range check, upper offset bits are ignored, so addresses alias modulo the RAM size.
- States: IDLE and BUSY.
- IDLE:
  - A strobe in cycle T latches mode/idx/wdata/wstrb, loads cnt=LATENCY-1, and moves to BUSY.
  - If LATENCY=1, the response is issued in cycle T+1 from BUSY with cnt=0.
- BUSY:
  - cnt decrements each cycle while nonzero.
  - When cnt==0, mem_response_enable=1 for exactly that cycle. This is cycle T+LATENCY for a request accepted in cycle T.
- Read: mem_data = RAM[idx] as it stood in the response cycle (reads issued after a write see the written data).
- Write:
  - Bytes with wstrb set are committed to RAM in the response cycle.
  - mem_data = 32'h0 on the write response.
  - wstrb=4'b0000 still produces a response but modifies nothing.
- Leaving the response cycle (cnt==0):
  - Skid buffer full: its request becomes active, cnt=LATENCY-1, stay BUSY.
  - Else, if a new strobe arrives in the same cycle: it becomes active directly, cnt=LATENCY-1, stay BUSY.
  - Otherwise: go to IDLE.
- Strobe while BUSY with cnt!=0:
  - Skid empty: store the request in the skid buffer.
  - Skid full: drop the request and set overflow.
- Strobe in the response cycle while skid is full:
  - The skid request becomes active.
  - The new strobe is stored in the skid buffer (freed the same cycle); it is not dropped.
- Sustained throughput is one response per LATENCY cycles. No response is ever issued for a dropped request.
- overflow clears only on rst.

Optional Feature:
- Macro: MEM_RESP_RANGE_CHECK_EN.
- Defined:
  - Adds output port `mem_err` (1 bit, reset 0), valid with mem_response_enable.
  - A request with off >= 4*2^ADDR_WIDTH gets mem_err=1 and mem_data=32'hDEAD_BEEF.
  - Out-of-range writes are discarded; latency is unchanged.
- Undefined:
  - No mem_err port.
  - Out-of-range addresses alias modulo the RAM size as described above.

Test Plan:
- Write then read: LATENCY=2; write addr 0x10, wdata 0xA5A5_1234, wstrb 4'hF, strobe in cycle 0 -> response in cycle 2 with data 0. Read 0x10 strobed in cycle 3 -> response in cycle 5 with mem_data=0xA5A5_1234.
- Byte strobe: word 0x20 = 0x1122_3344; write wdata 0xFFFF_FFFF with wstrb 4'b0101 -> subsequent read returns 0x11FF_33FF.
- Skid and overflow:
  - LATENCY=4; strobes in cycles 0, 1 and 2 (three reads).
  - Responses occur in cycles 4 and 8.
  - Third request is dropped and overflow=1 from cycle 3.
  - No third response is issued.
- Simultaneous strobe and response: LATENCY=2; strobes in cycles 0 and 2 -> responses in cycles 2 and 4; overflow stays 0.
- Reset mid-operation: strobe in cycle 0, rst high in cycle 1 -> no response in cycle 2. A fresh read after reset is served normally.
- Range (MEM_RESP_RANGE_CHECK_EN, ADDR_WIDTH=10, BASE_ADDR=0x8000_0000):
  - Read 0x8000_1000 -> mem_err=1, mem_data=0xDEAD_BEEF.
  - Without the macro the same read returns word 0.
